div_unit: RTL and testbench

Multi-cycle signed 32-bit integer divider for the Mini SRC datapath. It computes the quotient and remainder for the `div` instruction. Its results are loaded by the downstream HI/LO 32-bit registers on their enable. It uses a radix-2 restoring algorithm on operand magnitudes, followed by a sign-correction step. A start/busy/done handshake lets the control unit hold the HI/LO load enables until `done`.

---
 rtl/div_unit.sv | 155 +++++++++++++++
 tb/tb_div_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle signed divider: radix-2 restoring division on operand magnitudes,
// then a sign-correction step. Results feed the HI (remainder) / LO (quotient) registers.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Two's-complement magnitude; the most negative value maps to itself and is read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prem_d      = prem_q;
        dvs_d       = dvs_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        shifted = {prem_q, acc_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        unique case (state_q)
            S_IDLE: begin
                // The idle cycle right after completion is where done is high, so a
                // back-to-back start is accepted here.
                if (start) begin
                    dvd_neg_d = dividend[WIDTH-1];
                    dvs_neg_d = divisor[WIDTH-1];
                    acc_d     = mag(dividend);
                    dvs_d     = mag(divisor);
                    prem_d    = '0;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    zero_d    = (divisor == '0);
                    state_d   = (divisor == '0) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (!trial[WIDTH]) begin
                    prem_d = trial[WIDTH-1:0];
                    acc_d  = {acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted[WIDTH-1:0];
                    acc_d  = {acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (zero_q) begin
                    // acc_q still holds |dividend|; re-apply its sign to recover the original.
                    quotient_d  = '1;
                    remainder_d = dvd_neg_q ? -acc_q : acc_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = (dvd_neg_q ^ dvs_neg_q) ? -acc_q : acc_q;
                    remainder_d = dvd_neg_q ? -prem_q : prem_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            prem_q      <= '0;
            dvs_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prem_q      <= prem_d;
            dvs_q       <= dvs_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

    a_done_single : assert property (@(posedge clk) disable iff (!clr) done |=> !done);
    a_busy_done   : assert property (@(posedge clk) disable iff (!clr) !(busy && done));

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a scoreboard of expected results fed by the stimulus,
// drained by a monitor whenever done is seen, plus latency and handshake checks.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: C-style signed division (truncate toward zero), with the two special cases.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else if (a == 32'sh8000_0000 && b == -1) begin
            e.q = 32'h8000_0000;
            e.r = 32'h0;
            e.z = 1'b0;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every completed result against the oldest expectation.
    always @(negedge clk) begin
        if (clr === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done high with no outstanding operation at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("div_by_zero", 32'(div_by_zero), 32'(mon_e.z));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Counts edges after the accept edge until done; optional ignored start pulses at p1/p2.
    task automatic wait_done(input int exp_lat, input int p1, input int p2);
        int n = 0;
        bit seen = 1'b0;
        bit busy_ok = 1'b1;
        while (!seen && n < 100) begin
            if (n + 1 == p1 || n + 1 == p2) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        check("done_latency", n, exp_lat);
        check("busy_while_running", 32'(busy_ok), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("done_single_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int n;

        clr      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        clr = 1'b1;

        issue(32'd100, 32'd7);
        wait_done(34, 0, 0);
        issue(-32'sd100, 32'd7);
        wait_done(34, 0, 0);
        issue(32'd100, -32'sd7);
        wait_done(34, 0, 0);
        issue(-32'sd100, -32'sd7);
        wait_done(34, 0, 0);
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(34, 0, 0);
        issue(32'hFFFF_FFFF, 32'h8000_0000);
        wait_done(34, 0, 0);

        issue(32'd1234, 32'd0);
        wait_done(2, 0, 0);
        issue(32'd9, 32'd3);
        wait_done(34, 0, 0);

        // Start pulses with fresh operands mid-operation must be ignored.
        issue(32'd100, 32'd7);
        wait_done(34, 5, 20);

        // Mid-operation reset aborts the pending result.
        issue(32'd500, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        clr = 1'b0;
        sb.delete();
        #2;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        issue(32'd50, 32'd5);
        wait_done(34, 0, 0);

        // Back-to-back: start held high, second operands presented in the done cycle.
        @(negedge clk);
        dividend = 32'd81;
        divisor  = 32'd9;
        start    = 1'b1;
        sb.push_back(model(32'd81, 32'd9));
        @(posedge clk);
        #1;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_first_latency", n, 34);
        dividend = 32'd17;
        divisor  = 32'd5;
        sb.push_back(model(32'd17, 32'd5));
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("b2b_done_drops", 32'(done), 32'd0);
        check("b2b_busy_rises", 32'(busy), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("b2b_quotient_held", quotient, 32'd9);
        check("b2b_remainder_held", remainder, 32'd0);
        wait_done(14, 0, 0);

        // Randomized operations, biased toward zero and small divisors.
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(a, b);
            wait_done((b == 32'd0) ? 2 : 34, 0, 0);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
